// File: rtl/snap_pkg.sv
// snap_pkg: shared types and status bit positions for the snapshot capture blocks
package snap_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_CAPTURE, ST_DONE} snap_state_t;
  localparam int ST_DONE_BIT  = 31;
  localparam int ST_ARMED_BIT = 30;
  localparam int ST_CAPT_BIT  = 29;
endpackage

// File: rtl/snap_edge_det.sv
// snap_edge_det: registered rising-edge detector for software control bits
module snap_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);
  logic d_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) d_q <= 1'b0;
    else d_q <= d;
  assign rise = d & ~d_q;
endmodule

// File: rtl/snap_capture_ctrl.sv
// snap_capture_ctrl: arm/trigger sequencer writing one fixed-length burst into the snapshot BRAM
module snap_capture_ctrl
  import snap_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              user_clk,
  input  logic              user_rst_n,
  input  logic              ctrl_arm,
  input  logic              ctrl_trig_sel,
  input  logic              ctrl_valid_sel,
  input  logic              trig,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic              bram_we,
  output logic [31:0]       status
);
  snap_state_t state, state_nx;
  logic [ADDR_W:0] cnt, cnt_nx, cnt_inc;
  logic [31:0] status_nx;
  logic arm_edge, se, wr;
  snap_edge_det u_arm_edge (.clk(user_clk), .rst_n(user_rst_n), .d(ctrl_arm), .rise(arm_edge));
  assign se = ctrl_valid_sel ? din_valid : 1'b1;
  // arm edge always wins over a coincident trigger or sample
  assign wr = !arm_edge && se && (state == ST_CAPTURE || (state == ST_ARMED && trig));
  always_comb begin
    cnt_inc = cnt + 1'b1;
    state_nx = arm_edge ? (ctrl_trig_sel ? ST_ARMED : ST_CAPTURE)
             : wr ? (cnt_inc[ADDR_W] ? ST_DONE : ST_CAPTURE) : state;
    cnt_nx = arm_edge ? '0 : wr ? cnt_inc : cnt;
    status_nx = '0;
    status_nx[ST_DONE_BIT] = state_nx == ST_DONE;
    status_nx[ST_ARMED_BIT] = state_nx == ST_ARMED;
    status_nx[ST_CAPT_BIT] = state_nx == ST_CAPTURE;
    status_nx[ADDR_W:0] = cnt_nx;
  end
  always_ff @(posedge user_clk or negedge user_rst_n)
    if (!user_rst_n) begin
      state <= ST_IDLE;
      cnt <= '0;
      bram_we <= 1'b0;
      bram_addr <= '0;
      bram_din <= '0;
      status <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      bram_we <= wr;
      bram_addr <= wr ? cnt[ADDR_W-1:0] : bram_addr;
      bram_din <= wr ? din : bram_din;
      status <= status_nx;
    end
endmodule

// File: tb/tb_snap_capture_ctrl.sv
// tb_snap_capture_ctrl: directed scenarios with random data checked against a burst-level model
module tb_snap_capture_ctrl;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int WORDS = 1 << AW;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic arm = 1'b0, tsel = 1'b0, vsel = 1'b0, trig = 1'b0, dv = 1'b0;
  logic [DW-1:0] din = '0;
  logic [AW-1:0] addr;
  logic [DW-1:0] bdin;
  logic we;
  logic [31:0] status;
  int checks = 0, errors = 0, nwr = 0;
  // model: phase 0 idle, 1 waiting for trigger, 2 capturing, 3 burst complete
  int m_phase = 0, m_words = 0;
  bit m_arm_prev = 0, e_we = 0;
  int e_addr = 0;
  logic [DW-1:0] e_din = '0;
  snap_capture_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .user_clk(clk), .user_rst_n(rst_n), .ctrl_arm(arm), .ctrl_trig_sel(tsel),
    .ctrl_valid_sel(vsel), .trig(trig), .din(din), .din_valid(dv),
    .bram_addr(addr), .bram_din(bdin), .bram_we(we), .status(status)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] m_status();
    return {m_phase == 3, m_phase == 1, m_phase == 2, 29'(m_words)};
  endfunction
  task automatic m_reset();
    m_phase = 0; m_words = 0; m_arm_prev = 0; e_we = 0;
  endtask
  task automatic step();
    bit taken;
    taken = (vsel ? dv : 1'b1) && ((m_phase == 1 && trig) || m_phase == 2);
    e_we = 0;
    if (arm && !m_arm_prev) begin
      m_phase = tsel ? 1 : 2;
      m_words = 0;
    end else if (taken) begin
      e_we = 1; e_addr = m_words; e_din = din;
      m_words++;
      m_phase = (m_words == WORDS) ? 3 : 2;
    end
    m_arm_prev = arm;
    @(posedge clk); #1;
    chk("we", 32'(we), 32'(e_we));
    if (e_we) begin
      nwr++;
      chk("addr", 32'(addr), 32'(e_addr));
      chk("din", bdin, e_din);
    end
    chk("status", status, m_status());
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_we"}, 32'(we), 0);
    chk({tag, "_addr"}, 32'(addr), 0);
    chk({tag, "_din"}, bdin, 0);
    chk({tag, "_status"}, status, 0);
  endtask
  initial begin
    #1 chk_zero("rst");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1; m_reset();
    repeat (3) step();
    // immediate, ungated ramp
    arm = 1; step(); arm = 0;
    chk("imm_arm_status", status, 32'h2000_0000);
    nwr = 0;
    for (int k = 0; k < WORDS; k++) begin
      din = 32'h100 + k; step();
      chk("imm_addr", 32'(addr), k);
      chk("imm_data", bdin, 32'h100 + k);
    end
    chk("imm_last_status", status, 32'h8000_0010);
    for (int k = 0; k < 5; k++) begin din = $urandom; step(); end
    chk("imm_nwr", nwr, WORDS);
    // triggered, gated
    tsel = 1; vsel = 1; arm = 1; step(); arm = 0;
    for (int k = 0; k < 4; k++) begin din = $urandom; dv = $urandom; step(); end
    chk("trg_wait_status", status, 32'h4000_0000);
    trig = 1; dv = 0; step();
    chk("trg_ignored_we", 32'(we), 0);
    chk("trg_ignored_status", status, 32'h4000_0000);
    dv = 1; din = 32'hAB; nwr = 0; step(); trig = 0;
    chk("trg_first_addr", 32'(addr), 0);
    chk("trg_first_data", bdin, 32'hAB);
    for (int k = 0; k < 200 && m_phase != 3; k++) begin
      din = $urandom; dv = $urandom; trig = $urandom; step();
    end
    chk("trg_nwr", nwr, WORDS);
    chk("trg_done_status", status, 32'h8000_0010);
    // re-arm mid-capture
    tsel = 0; vsel = 0; trig = 0; arm = 1; step(); arm = 0;
    for (int k = 0; k < 7; k++) begin din = $urandom; step(); end
    arm = 1; din = $urandom; step(); arm = 0;
    chk("rearm_we", 32'(we), 0);
    chk("rearm_status", status, 32'h2000_0000);
    nwr = 0;
    din = $urandom; step();
    chk("rearm_first_addr", 32'(addr), 0);
    for (int k = 0; k < 20; k++) begin din = $urandom; step(); end
    chk("rearm_nwr", nwr, WORDS);
    // arm held high
    nwr = 0; arm = 1;
    for (int k = 0; k < 50; k++) begin din = $urandom; trig = $urandom; step(); end
    chk("held_nwr", nwr, WORDS);
    chk("held_status", status, 32'h8000_0010);
    arm = 0;
    for (int k = 0; k < 3; k++) step();
    // reset mid-capture with arm held
    arm = 1; step();
    nwr = 0;
    while (nwr < 5) begin din = $urandom; step(); end
    rst_n = 0; m_reset();
    #1 chk_zero("midrst");
    @(posedge clk); @(negedge clk);
    rst_n = 1;
    nwr = 0;
    for (int k = 0; k < 25; k++) begin din = $urandom; step(); end
    chk("midrst_nwr", nwr, WORDS);
    // DONE ignores inputs
    arm = 0; tsel = 1; nwr = 0;
    for (int k = 0; k < 20; k++) begin
      trig = $urandom; dv = $urandom; vsel = $urandom; din = $urandom; step();
      chk("done_we", 32'(we), 0);
      chk("done_status", status, 32'h8000_0010);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
